// File: rtl/data_memory_ctrl.sv
// Word-addressed synchronous data RAM with byte-lane writes, registered reads,
// write-first forwarding, out-of-range detection and a clear sweep after reset.
module data_memory_ctrl #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DEPTH  = 256
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic [ADDR_W-1:0]   Adresa,
  input  logic [DATA_W-1:0]   WriteData,
  input  logic [DATA_W/8-1:0] ByteEn,
  input  logic                MemWrite,
  input  logic                MemRead,
  output logic [DATA_W-1:0]   ReadData,
  output logic                ReadValid,
  output logic                Ready,
  output logic                AddrError
);

  localparam int unsigned NB    = DATA_W / 8;
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [0:0] {StInit, StRun} state_e;

  state_e             state_q;
  logic [IDX_W-1:0]   cnt_q;
  logic [DATA_W-1:0]  mem [DEPTH];

  logic               in_range;
  logic [IDX_W-1:0]   addr_idx;
  logic [DATA_W-1:0]  old_word;
  logic [DATA_W-1:0]  merged;
  logic [DATA_W-1:0]  rd_word;
  logic               wr_en;
  logic               sweep_last;

  // Full-width compare: upper address bits are never truncated, so no aliasing.
  assign in_range   = ({1'b0, Adresa} < (ADDR_W + 1)'(DEPTH));
  assign addr_idx   = Adresa[IDX_W-1:0];
  assign old_word   = mem[addr_idx];
  assign sweep_last = (cnt_q == IDX_W'(DEPTH - 1));

  always_comb begin
    merged = old_word;
    for (int i = 0; i < NB; i++) begin
      if (ByteEn[i]) begin
        merged[8*i +: 8] = WriteData[8*i +: 8];
      end
    end
  end

  assign wr_en = (state_q == StRun) && MemWrite && in_range && (|ByteEn);

  // Write-first: a same-edge write is visible to the read on its enabled lanes.
  always_comb begin
    rd_word = '0;
    if (in_range) begin
      rd_word = MemWrite ? merged : old_word;
    end
  end

  // Storage has no reset; the sweep clears it word by word after reset.
  always_ff @(posedge Clock) begin
    if (state_q == StInit) begin
      mem[cnt_q] <= '0;
    end else if (wr_en) begin
      mem[addr_idx] <= merged;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q   <= StInit;
      cnt_q     <= '0;
      ReadData  <= '0;
      ReadValid <= 1'b0;
      Ready     <= 1'b0;
      AddrError <= 1'b0;
    end else begin
      ReadValid <= 1'b0;
      AddrError <= 1'b0;
      unique case (state_q)
        StInit: begin
          cnt_q <= cnt_q + 1'b1;
          if (sweep_last) begin
            state_q <= StRun;
            Ready   <= 1'b1;
          end
        end
        StRun: begin
          if (MemRead) begin
            ReadData  <= rd_word;
            ReadValid <= 1'b1;
          end
          if ((MemRead || MemWrite) && !in_range) begin
            AddrError <= 1'b1;
          end
        end
        default: state_q <= StInit;
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Directed self-checking bench for data_memory_ctrl (DATA_W=16, ADDR_W=16, DEPTH=16).
module tb_data_memory_ctrl;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic [15:0] Adresa = '0;
  logic [15:0] WriteData = '0;
  logic [1:0]  ByteEn = '0;
  logic        MemWrite = 1'b0;
  logic        MemRead = 1'b0;
  logic [15:0] ReadData;
  logic        ReadValid;
  logic        Ready;
  logic        AddrError;

  int errors = 0;
  int checks = 0;

  data_memory_ctrl #(
    .DATA_W(16),
    .ADDR_W(16),
    .DEPTH (16)
  ) dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .Adresa   (Adresa),
    .WriteData(WriteData),
    .ByteEn   (ByteEn),
    .MemWrite (MemWrite),
    .MemRead  (MemRead),
    .ReadData (ReadData),
    .ReadValid(ReadValid),
    .Ready    (Ready),
    .AddrError(AddrError)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // Apply one request for a single edge, then return inputs to idle.
  task automatic op(input logic rd, input logic wr, input logic [15:0] addr,
                    input logic [15:0] wd, input logic [1:0] be);
    MemRead   = rd;
    MemWrite  = wr;
    Adresa    = addr;
    WriteData = wd;
    ByteEn    = be;
    tick();
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    ByteEn    = '0;
  endtask

  initial begin
    // Reset state
    tick();
    check("rst_ready", 32'(Ready), 32'd0);
    check("rst_rdata", 32'(ReadData), 32'd0);
    check("rst_rvalid", 32'(ReadValid), 32'd0);
    check("rst_aerr", 32'(AddrError), 32'd0);
    Reset = 1'b0;

    // Abort the first sweep part-way through
    for (int e = 1; e <= 8; e++) tick();
    check("mid_sweep_ready", 32'(Ready), 32'd0);
    #2 Reset = 1'b1;
    #1 check("mid_sweep_rst_ready", 32'(Ready), 32'd0);
    tick();
    Reset = 1'b0;

    // Test 1: Ready rises exactly on edge 16
    for (int e = 1; e <= 16; e++) begin
      tick();
      check($sformatf("sweep_ready_e%0d", e), 32'(Ready), (e == 16) ? 32'd1 : 32'd0);
    end
    for (int a = 0; a < 16; a++) begin
      op(1'b1, 1'b0, 16'(a), 16'h0000, 2'b00);
      check($sformatf("clear_rd_a%0d", a), 32'(ReadData), 32'h0000);
      check($sformatf("clear_rv_a%0d", a), 32'(ReadValid), 32'd1);
    end
    tick();
    check("idle_rv", 32'(ReadValid), 32'd0);

    // Test 2: full write then read
    op(1'b0, 1'b1, 16'd2, 16'h0069, 2'b11);
    check("t2_wr_rv", 32'(ReadValid), 32'd0);
    check("t2_wr_aerr", 32'(AddrError), 32'd0);
    op(1'b1, 1'b0, 16'd2, 16'h0000, 2'b00);
    check("t2_rd", 32'(ReadData), 32'h0069);
    check("t2_rv", 32'(ReadValid), 32'd1);

    // Test 3: upper lane only
    op(1'b0, 1'b1, 16'd2, 16'hAB00, 2'b10);
    op(1'b1, 1'b0, 16'd2, 16'h0000, 2'b00);
    check("t3_rd", 32'(ReadData), 32'hAB69);

    // Test 4: same-edge write-first on lower lane
    op(1'b1, 1'b1, 16'd2, 16'h1234, 2'b01);
    check("t4_rd", 32'(ReadData), 32'hAB34);
    check("t4_rv", 32'(ReadValid), 32'd1);
    tick();
    check("t4_hold", 32'(ReadData), 32'hAB34);
    check("t4_hold_rv", 32'(ReadValid), 32'd0);
    op(1'b1, 1'b0, 16'd2, 16'h0000, 2'b00);
    check("t4_reread", 32'(ReadData), 32'hAB34);

    // Test 5: out of range
    op(1'b0, 1'b1, 16'd20, 16'hFFFF, 2'b11);
    check("t5_wr_aerr", 32'(AddrError), 32'd1);
    check("t5_wr_rv", 32'(ReadValid), 32'd0);
    tick();
    check("t5_aerr_pulse", 32'(AddrError), 32'd0);
    op(1'b1, 1'b0, 16'd20, 16'h0000, 2'b00);
    check("t5_rd", 32'(ReadData), 32'h0000);
    check("t5_rv", 32'(ReadValid), 32'd1);
    check("t5_rd_aerr", 32'(AddrError), 32'd1);
    op(1'b1, 1'b0, 16'd4, 16'h0000, 2'b00);
    check("t5_alias", 32'(ReadData), 32'h0000);
    check("t5_alias_aerr", 32'(AddrError), 32'd0);

    // Test 6: reset after data is present
    op(1'b1, 1'b0, 16'd2, 16'h0000, 2'b00);
    check("t6_pre", 32'(ReadData), 32'hAB34);
    #2 Reset = 1'b1;
    #1;
    check("t6_ready", 32'(Ready), 32'd0);
    check("t6_rdata", 32'(ReadData), 32'h0000);
    tick();
    Reset = 1'b0;
    // Requests during the sweep must be ignored
    MemRead   = 1'b1;
    MemWrite  = 1'b1;
    Adresa    = 16'd2;
    WriteData = 16'hFFFF;
    ByteEn    = 2'b11;
    for (int e = 1; e <= 16; e++) begin
      tick();
      check($sformatf("t6_ready_e%0d", e), 32'(Ready), (e == 16) ? 32'd1 : 32'd0);
      check($sformatf("t6_rv_e%0d", e), 32'(ReadValid), 32'd0);
    end
    MemWrite = 1'b0;
    ByteEn   = '0;
    op(1'b1, 1'b0, 16'd2, 16'h0000, 2'b00);
    check("t6_rd", 32'(ReadData), 32'h0000);
    check("t6_rv", 32'(ReadValid), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
